// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared types and defaults for the 2x2 systolic drain
package sa_pkg;

    localparam int SA_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2
    } sa_state_e;

    typedef struct packed {
        logic [SA_DATA_W-1:0] row1;
        logic [SA_DATA_W-1:0] row2;
        logic                 last;
    } sa_row_t;

endpackage

// File: rtl/sa_row_fifo.sv
// rtl/sa_row_fifo.sv - aligned-row buffer, push/full write side, valid/ready read side
module sa_row_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] s_tdata,
    input  logic         s_tvalid,
    output logic         s_full,
    output logic [W-1:0] m_tdata,
    output logic         m_tvalid,
    input  logic         m_tready
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          pop;
    logic          push_ok;

    assign s_full   = (count_q == FULL_CNT);
    assign m_tvalid = (count_q != '0);
    assign pop      = m_tvalid && m_tready;
    // A pop on the same edge frees the slot, so a push into a full buffer is still taken.
    assign push_ok  = s_tvalid && (!s_full || pop);
    // Head is forced to zero when empty so stale entries never show on the outputs.
    assign m_tdata  = m_tvalid ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = s_tdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/sa2x2_drain.sv
// rtl/sa2x2_drain.sv - deskews and buffers 2-column systolic array results row by row
module sa2x2_drain
    import sa_pkg::*;
#(
    parameter int DATA_W     = SA_DATA_W,
    parameter int FIRST_LAT  = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [3:0]        num_rows,
    input  logic [DATA_W-1:0] psum_in1,
    input  logic [DATA_W-1:0] psum_in2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_row1,
    output logic [DATA_W-1:0] out_row2,
    output logic              out_last,
    output logic              busy,
    output logic              overflow
);

    localparam int RW = 2 * DATA_W + 1;
    // WAIT holds FIRST_LAT-1 cycles; its counter ends at FIRST_LAT-2.
    localparam logic [3:0] WAIT_LAST = (FIRST_LAT >= 2) ? 4'(FIRST_LAT - 2) : 4'd0;

    sa_state_e         state_q, state_d;
    logic [3:0]        rows_q, rows_d;
    logic [3:0]        wcnt_q, wcnt_d;
    logic [3:0]        ccnt_q, ccnt_d;
    logic [DATA_W-1:0] col1_q, col1_d;
    logic              overflow_q, overflow_d;

    logic              push;
    logic              push_last;
    logic              fifo_full;
    logic              pop;
    logic [RW-1:0]     wr_tdata;
    logic [RW-1:0]     rd_tdata;

    always_comb begin
        state_d    = state_q;
        rows_d     = rows_q;
        wcnt_d     = wcnt_q;
        ccnt_d     = ccnt_q;
        col1_d     = col1_q;
        push       = 1'b0;
        push_last  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && (num_rows != 4'd0)) begin
                    rows_d  = num_rows;
                    wcnt_d  = 4'd0;
                    ccnt_d  = 4'd0;
                    state_d = (FIRST_LAT == 1) ? ST_CAPTURE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wcnt_q == WAIT_LAST) begin
                    state_d = ST_CAPTURE;
                end else begin
                    wcnt_d = wcnt_q + 4'd1;
                end
            end
            ST_CAPTURE: begin
                // Capture cycle c registers col1 of row c and, from c=1, pushes row c-1
                // together with the live col2 that lags by one cycle.
                if (ccnt_q != rows_q) begin
                    col1_d = psum_in1;
                end
                if (ccnt_q != 4'd0) begin
                    push      = 1'b1;
                    push_last = (ccnt_q == rows_q);
                end
                if (ccnt_q == rows_q) begin
                    state_d = ST_IDLE;
                end else begin
                    ccnt_d = ccnt_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign pop      = out_valid && out_ready;
    assign wr_tdata = {col1_q, psum_in2, push_last};

    always_comb begin
        overflow_d = overflow_q;
        if (push && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rows_q     <= 4'd0;
            wcnt_q     <= 4'd0;
            ccnt_q     <= 4'd0;
            col1_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rows_q     <= rows_d;
            wcnt_q     <= wcnt_d;
            ccnt_q     <= ccnt_d;
            col1_q     <= col1_d;
            overflow_q <= overflow_d;
        end
    end

    sa_row_fifo #(
        .W     (RW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_tdata  (wr_tdata),
        .s_tvalid (push),
        .s_full   (fifo_full),
        .m_tdata  (rd_tdata),
        .m_tvalid (out_valid),
        .m_tready (out_ready)
    );

    assign out_row1 = rd_tdata[RW-1 -: DATA_W];
    assign out_row2 = rd_tdata[DATA_W -: DATA_W];
    assign out_last = rd_tdata[0];
    assign busy     = (state_q != ST_IDLE);
    assign overflow = overflow_q;

endmodule

// File: doc/sa2x2_drain.md
SA2X2_DRAIN -- requirements
Module: sa2x2_drain

Interface
REQ-001 Parameter DATA_W, default 8: psum element width.
REQ-002 Parameter FIRST_LAT, default 3: cycles from accepted start to the first column-1 psum; legal range 1..15.
REQ-003 Parameter FIFO_DEPTH, default 4: aligned-row buffer depth; power of two, at least 2.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Port start, input, 1: one-cycle request to drain one result block.
REQ-007 Port num_rows, input, 4: row count of the block, sampled with start.
REQ-008 Port psum_in1 / psum_in2, input, DATA_W each: array bottom-edge outputs; column 2 lags column 1 by one cycle.
REQ-009 Port out_valid, output, 1: aligned row available.
REQ-010 Port out_ready, input, 1: consumer accepts the row.
REQ-011 Port out_row1 / out_row2, output, DATA_W each: column-1 and column-2 results of one row.
REQ-012 Port out_last, output, 1: the presented row is row num_rows-1 of its block.
REQ-013 Port busy, output, 1: high whenever state is not IDLE.
REQ-014 Port overflow, output, 1: sticky; a completed row was dropped.

Function
REQ-015 FSM states: IDLE, WAIT, CAPTURE.
REQ-016 IDLE to WAIT on an edge where start=1 and num_rows!=0; num_rows is latched on that edge (edge T0).
REQ-017 start with num_rows=0, or start outside IDLE, is ignored with no state change.
REQ-018 WAIT lasts FIRST_LAT-1 cycles; the FSM enters CAPTURE so that psum_in1 is sampled on edge T0+FIRST_LAT.
REQ-019 Row r (0..N-1): psum_in1 is registered on edge T0+FIRST_LAT+r; psum_in2 is sampled on edge T0+FIRST_LAT+r+1, and {registered col1, live col2, last=(r==N-1)} is pushed on that same edge.
REQ-020 CAPTURE lasts N+1 cycles, then returns to IDLE; busy falls after the push of the final row.
REQ-021 The array cannot stall: a push when the FIFO is full while no pop occurs on that edge drops the row and sets overflow; the row count still advances.
REQ-022 Simultaneous push and pop on a full FIFO is legal and loses no data.
REQ-023 Pop occurs on an edge where out_valid=1 and out_ready=1.
REQ-024 out_valid, out_row*, and out_last are driven from the FIFO head, with zero-cycle output latency after the push edge.
REQ-025 out_row* hold steady while out_valid=1 and out_ready=0.
REQ-026 FIFO pointers wrap modulo FIFO_DEPTH; a count register distinguishes full from empty.
REQ-027 Data passes unmodified; no arithmetic is performed on psums.
REQ-028 overflow clears only on reset.

Reset
REQ-029 rst_n low asynchronously forces state IDLE and clears the row counter, FIFO pointers, count, and overflow; out_valid, out_last, busy, and overflow read 0; out_row* read 0.
REQ-030 Reset asserted mid-CAPTURE discards the partial block and all buffered rows; nothing is pushed on release.
REQ-031 The first start is honoured on the first rising edge after rst_n deasserts.

Structure
REQ-032 A shared package sa_pkg holds DATA_W default, the FSM state enum, and the row-record typedef {row1, row2, last}.
REQ-033 The FIFO is one sub-module, sa_row_fifo (parameterised width/depth, valid/ready read side, push/full write side); the FSM, skew register, and counters live in sa2x2_drain.

Verification
REQ-034 2x2 result drain, FIRST_LAT=3: start with N=2 at T0; psum_in1=6,10 at T0+3,+4; psum_in2=10,16 at T0+4,+5; out_ready=1 -> rows (6,10,last=0) then (10,16,last=1); busy low after T0+5.
REQ-035 Backpressure: same stimulus, out_ready=0 until T0+10 -> both rows held stable in order; out_valid stays 1; no overflow.
REQ-036 Overflow: FIFO_DEPTH=4, N=6, out_ready=0 -> rows 0-3 kept, rows 4-5 dropped, overflow=1; after draining, 4 rows are delivered and overflow stays 1.
REQ-037 Ignored starts: start with num_rows=0 -> busy stays 0; start during CAPTURE -> no effect on the current block's row count.
REQ-038 Mid-operation reset: pulse rst_n low at T0+4 of an N=2 block -> out_valid=0 immediately; no rows after release; a fresh start drains correctly.
REQ-039 Full and pop together: FIFO full, out_ready=1 on the edge of a new push -> count unchanged, no overflow, order preserved.
